// File: rtl/ram_march_bist_if.sv
// RAM-side port bundle for the march BIST: address/data/write-enable out, read data in.
interface ram_march_bist_if #(
  parameter int AW = 7,
  parameter int DW = 8
);
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  modport master (output mem_a, output mem_d, output mem_we, input mem_q);
  modport slave  (input mem_a, input mem_d, input mem_we, output mem_q);
endinterface

// File: rtl/ram_march_bist.sv
// March BIST initiator for a single-port sync-write RAM.
// Sequence: P0 up write pat, P1 up read pat / write ~pat, P2 down read ~pat / write pat,
// P3 up read pat. Records first mismatch and a saturating mismatch count.
module ram_march_bist #(
  parameter int AW     = 7,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DW-1:0]           pattern,
  ram_march_bist_if.master        mem,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [AW-1:0]           fail_addr,
  output logic [DW-1:0]           fail_exp,
  output logic [DW-1:0]           fail_got,
  output logic [7:0]              err_cnt
);

  typedef enum logic [3:0] {
    IDLE, P0_W,
    P1_RD, P1_WT, P1_WR,
    P2_RD, P2_WT, P2_WR,
    P3_RD, P3_WT, P3_CK,
    DONE
  } state_t;

  localparam logic [AW-1:0] AMAX    = '1;
  localparam logic [1:0]    WT_LAST = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  localparam bit            NO_WAIT = (RD_LAT == 1);

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [1:0]    wcnt, wcnt_n;
  logic [DW-1:0] pat_r, pat_n;

  logic [AW-1:0] a_n;
  logic [DW-1:0] d_n;
  logic          we_n, busy_n, done_n;

  logic [DW-1:0] exp_d;
  logic          cmp_en, mismatch;

  // State, address, wait counter and captured pattern registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      wcnt  <= '0;
      pat_r <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      wcnt  <= wcnt_n;
      pat_r <= pat_n;
    end
  end

  // Next-state / address sequencing through the four march phases.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    wcnt_n  = wcnt;
    pat_n   = pat_r;
    unique case (state)
      IDLE: if (start) begin
        state_n = P0_W;
        addr_n  = '0;
        pat_n   = pattern;
      end
      P0_W: begin
        addr_n = addr + 1'b1;
        if (addr == AMAX) state_n = P1_RD;
      end
      P1_RD, P2_RD, P3_RD: begin
        wcnt_n = '0;
        if (state == P1_RD)      state_n = NO_WAIT ? P1_WR : P1_WT;
        else if (state == P2_RD) state_n = NO_WAIT ? P2_WR : P2_WT;
        else                     state_n = NO_WAIT ? P3_CK : P3_WT;
      end
      P1_WT, P2_WT, P3_WT: begin
        wcnt_n = wcnt + 1'b1;
        if (wcnt == WT_LAST) begin
          if (state == P1_WT)      state_n = P1_WR;
          else if (state == P2_WT) state_n = P2_WR;
          else                     state_n = P3_CK;
        end
      end
      // P1 ends at max and P2 starts there, so the address is held across the turn.
      P1_WR: if (addr == AMAX) state_n = P2_RD;
             else begin addr_n = addr + 1'b1; state_n = P1_RD; end
      // P2 ends at 0 and P3 starts there.
      P2_WR: if (addr == '0) state_n = P3_RD;
             else begin addr_n = addr - 1'b1; state_n = P2_RD; end
      P3_CK: if (addr == AMAX) state_n = DONE;
             else begin addr_n = addr + 1'b1; state_n = P3_RD; end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next RAM port and status values, decoded from the upcoming state so they register in step with it.
  always_comb begin
    a_n    = addr_n;
    d_n    = '0;
    we_n   = 1'b0;
    busy_n = 1'b1;
    done_n = 1'b0;
    unique case (state_n)
      IDLE:    begin busy_n = 1'b0; a_n = '0; end
      DONE:    begin busy_n = 1'b0; done_n = 1'b1; end
      P0_W:    begin d_n = pat_n;  we_n = 1'b1; end
      P1_WR:   begin d_n = ~pat_n; we_n = 1'b1; end
      P2_WR:   begin d_n = pat_n;  we_n = 1'b1; end
      default: ;
    endcase
  end

  // Registered RAM port and run status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_a  <= '0;
      mem.mem_d  <= '0;
      mem.mem_we <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem.mem_a  <= a_n;
      mem.mem_d  <= d_n;
      mem.mem_we <= we_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Expected read data for the current compare state.
  always_comb begin
    cmp_en   = (state == P1_WR) || (state == P2_WR) || (state == P3_CK);
    exp_d    = (state == P2_WR) ? ~pat_r : pat_r;
    mismatch = cmp_en && (mem.mem_q != exp_d);
  end

  // Mismatch bookkeeping: first-fail capture and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_cnt   <= '0;
    end else if (state == IDLE && start) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_cnt   <= '0;
    end else if (mismatch) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= addr;
        fail_exp  <= exp_d;
        fail_got  <= mem.mem_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two DUTs (RD_LAT 1 and 2), behavioural RAMs with an injectable
// stuck-bit fault, and a march model that predicts every busy cycle and the final result.
module tb_ram_march_bist;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int D  = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start2;
  logic [7:0] pattern1, pattern2;
  logic       busy1, done1, fail1, busy2, done2, fail2;
  logic [6:0] fa1, fa2;
  logic [7:0] fe1, fg1, ec1, fe2, fg2, ec2;

  ram_march_bist_if #(.AW(AW), .DW(DW)) bus1 ();
  ram_march_bist_if #(.AW(AW), .DW(DW)) bus2 ();

  ram_march_bist #(.AW(AW), .DW(DW), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pattern(pattern1), .mem(bus1.master),
    .busy(busy1), .done(done1), .fail(fail1), .fail_addr(fa1), .fail_exp(fe1),
    .fail_got(fg1), .err_cnt(ec1));

  ram_march_bist #(.AW(AW), .DW(DW), .RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pattern(pattern2), .mem(bus2.master),
    .busy(busy2), .done(done2), .fail(fail2), .fail_addr(fa2), .fail_exp(fe2),
    .fail_got(fg2), .err_cnt(ec2));

  // Fault: reads of f_addr return (stored & ~f_m0) | f_m1.
  logic [6:0] f_addr;
  logic [7:0] f_m1, f_m0;

  function automatic logic [7:0] fread(input logic [7:0] v, input logic [6:0] a);
    return (a == f_addr) ? ((v & ~f_m0) | f_m1) : v;
  endfunction

  logic [7:0] ram1 [D];
  logic [7:0] ram2 [D];
  logic [7:0] q1, q2a, q2;

  always @(posedge clk) begin
    q1 <= fread(ram1[bus1.mem_a], bus1.mem_a);
    if (bus1.mem_we) ram1[bus1.mem_a] <= bus1.mem_d;
  end
  always @(posedge clk) begin
    q2a <= fread(ram2[bus2.mem_a], bus2.mem_a);
    q2  <= q2a;
    if (bus2.mem_we) ram2[bus2.mem_a] <= bus2.mem_d;
  end
  assign bus1.mem_q = q1;
  assign bus2.mem_q = q2;

  // Monitored instance selection.
  bit         sel;
  logic       m_busy, m_done, m_we, m_fail;
  logic [6:0] m_a, m_fa;
  logic [7:0] m_d, m_fe, m_fg, m_ec;
  always_comb begin
    if (sel) begin
      m_busy = busy2; m_done = done2; m_we = bus2.mem_we; m_a = bus2.mem_a; m_d = bus2.mem_d;
      m_fail = fail2; m_fa = fa2; m_fe = fe2; m_fg = fg2; m_ec = ec2;
    end else begin
      m_busy = busy1; m_done = done1; m_we = bus1.mem_we; m_a = bus1.mem_a; m_d = bus1.mem_d;
      m_fail = fail1; m_fa = fa1; m_fe = fe1; m_fg = fg1; m_ec = ec1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected per-busy-cycle RAM port activity.
  typedef struct {
    bit         chk_a;
    logic [6:0] a;
    bit         chk_d;
    logic [7:0] d;
    logic       we;
  } op_t;

  op_t stage_q[$];
  op_t exp_q[$];

  logic [7:0] mdl_mem [D];
  int         mdl_err;
  logic       mdl_fail;
  logic [6:0] mdl_fa;
  logic [7:0] mdl_fe, mdl_fg;

  function automatic void push(input bit ca, input logic [6:0] a, input bit cd,
                               input logic [7:0] d, input logic we);
    op_t o;
    o.chk_a = ca; o.a = a; o.chk_d = cd; o.d = d; o.we = we;
    stage_q.push_back(o);
  endfunction

  // March model on a plain array: builds the cycle list and the final outcome.
  task automatic build(input logic [7:0] pat, input int lat);
    logic [6:0] a;
    logic [7:0] e, got;
    stage_q.delete();
    mdl_err = 0; mdl_fail = 1'b0; mdl_fa = '0; mdl_fe = '0; mdl_fg = '0;
    for (int i = 0; i < D; i++) begin
      push(1'b1, 7'(i), 1'b1, pat, 1'b1);
      mdl_mem[i] = pat;
    end
    for (int p = 1; p <= 3; p++) begin
      for (int k = 0; k < D; k++) begin
        a = 7'((p == 2) ? (D - 1 - k) : k);
        e = (p == 2) ? ~pat : pat;
        push(1'b1, a, 1'b0, '0, 1'b0);
        for (int w = 1; w < lat; w++) push(1'b0, '0, 1'b0, '0, 1'b0);
        got = fread(mdl_mem[a], a);
        if (got != e) begin
          if (mdl_err < 255) mdl_err++;
          if (!mdl_fail) begin
            mdl_fail = 1'b1; mdl_fa = a; mdl_fe = e; mdl_fg = got;
          end
        end
        if (p < 3) begin
          push(1'b1, a, 1'b1, ~e, 1'b1);
          mdl_mem[a] = ~e;
        end else begin
          push(1'b0, '0, 1'b0, '0, 1'b0);
        end
      end
    end
  endtask

  int busy_w = 0;
  int done_cnt = 0;

  // Cycle compare: every busy cycle must match the next predicted port activity.
  always @(negedge clk) begin
    op_t e;
    if (m_busy) busy_w++;
    if (m_done) done_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy_done_run", {m_busy, m_done}, 2'b10);
      chk("mem_we", m_we, e.we);
      if (e.chk_a) chk("mem_a", m_a, e.a);
      if (e.chk_d) chk("mem_d", m_d, e.d);
    end
  end

  task automatic set_start(input logic v);
    if (sel) start2 = v; else start1 = v;
  endtask
  task automatic set_pat(input logic [7:0] v);
    if (sel) pattern2 = v; else pattern1 = v;
  endtask

  task automatic run(input logic [7:0] pat, input int lat, input int pulse_at,
                     input int chg_at, input logic [7:0] pat2);
    int cyc, bw0, dc0, nbad;
    sel = (lat == 2);
    build(pat, lat);
    @(posedge clk); #1;
    set_pat(pat);
    set_start(1'b1);
    @(posedge clk); #1;
    exp_q = stage_q;
    set_start(1'b0);
    bw0 = busy_w; dc0 = done_cnt; cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == pulse_at) set_start(1'b1);
      if (cyc == pulse_at + 1) set_start(1'b0);
      if (cyc == chg_at) set_pat(pat2);
    end
    chk("run_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse", {m_busy, m_done}, 2'b01);
    @(negedge clk);
    chk("after_done", {m_busy, m_done}, 2'b00);
    chk("busy_width", busy_w - bw0, (lat == 1) ? 896 : 1280);
    chk("done_count", done_cnt - dc0, 1);
    chk("fail", m_fail, mdl_fail);
    chk("err_cnt", m_ec, mdl_err);
    if (mdl_fail) begin
      chk("fail_addr", m_fa, mdl_fa);
      chk("fail_exp", m_fe, mdl_fe);
      chk("fail_got", m_fg, mdl_fg);
    end
    nbad = 0;
    for (int i = 0; i < D; i++)
      if ((sel ? ram2[i] : ram1[i]) !== mdl_mem[i]) nbad++;
    chk("final_contents", nbad, 0);
  endtask

  task automatic no_fault();
    f_addr = '0; f_m1 = '0; f_m0 = '0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b1; start1 = 1'b0; start2 = 1'b0; pattern1 = '0; pattern2 = '0;
    sel = 1'b0;
    no_fault();
    #2 rst_n = 1'b0;
    #20;
    chk("reset_u1_a", {busy1, done1, fail1, ec1, fa1, bus1.mem_we}, 0);
    chk("reset_u1_b", {fe1, fg1, bus1.mem_a, bus1.mem_d}, 0);
    chk("reset_u2_a", {busy2, done2, fail2, ec2, fa2, bus2.mem_we}, 0);
    chk("reset_u2_b", {fe2, fg2, bus2.mem_a, bus2.mem_d}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Good RAM, F0.
    run(8'hF0, 1, -1, -1, 8'h00);
    chk("t1_err_lit", ec1, 8'd0);
    chk("t1_fail_lit", fail1, 1'b0);

    // Bit0 stuck-at-1 at address 5.
    f_addr = 7'h05; f_m1 = 8'h01; f_m0 = 8'h00;
    run(8'hF0, 1, -1, -1, 8'h00);
    chk("t2_fail_lit", fail1, 1'b1);
    chk("t2_addr_lit", fa1, 7'h05);
    chk("t2_exp_lit", fe1, 8'hF0);
    chk("t2_got_lit", fg1, 8'hF1);
    chk("t2_err_lit", ec1, 8'd2);
    no_fault();

    // Start pulse while busy must be ignored.
    run(8'($urandom), 1, 100, -1, 8'h00);

    // Reset mid-run, with a fault so fail is already set beforehand.
    sel = 1'b0;
    f_addr = 7'h03; f_m1 = 8'h80; f_m0 = 8'h00;
    build(8'h3C, 1);
    @(posedge clk); #1 pattern1 = 8'h3C; start1 = 1'b1;
    @(posedge clk); #1 exp_q = stage_q; start1 = 1'b0;
    repeat (300) begin @(posedge clk); #1; end
    chk("pre_reset_fail", fail1, 1'b1);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_reset_we", bus1.mem_we, 1'b0);
    chk("mid_reset_busy", busy1, 1'b0);
    chk("mid_reset_a", {done1, fail1, ec1, fa1}, 0);
    chk("mid_reset_b", {fe1, fg1, bus1.mem_a, bus1.mem_d}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("idle_hold", {busy1, done1, bus1.mem_we}, 3'b000);
    end
    no_fault();

    // Two-cycle read latency.
    run(8'hF0, 2, -1, -1, 8'h00);

    // Pattern change during the run has no effect.
    run(8'hF0, 1, -1, 200, 8'h00);
    chk("t6_err_lit", ec1, 8'd0);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      lat = int'($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1) begin
        f_addr = 7'($urandom_range(0, D - 1));
        f_m1 = 8'($urandom);
        f_m0 = 8'($urandom);
      end else begin
        no_fault();
      end
      run(8'($urandom), lat, -1, -1, 8'h00);
    end
    no_fault();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
